// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: display geometry, fill FSM states and the latched fill command.
package vga_fb_pkg;
  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int H_SIZE = 10;
  localparam int V_SIZE = 10;
  localparam int CMD_RGB_W = 16;
  typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} fill_state_t;
  typedef struct packed {
    logic [H_SIZE-1:0] x0;
    logic [H_SIZE-1:0] x1;
    logic [V_SIZE-1:0] y0;
    logic [V_SIZE-1:0] y1;
    logic [CMD_RGB_W-1:0] rgb;
  } fill_cmd_t;
endpackage

// File: rtl/vga_fb_addr_gen.sv
// vga_fb_addr_gen: row-major x/y walk over a clipped rectangle with an adder-only row base.
module vga_fb_addr_gen import vga_fb_pkg::*; #(
  parameter int AW = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [H_SIZE-1:0] xl,
  input  logic [H_SIZE-1:0] xr,
  input  logic [V_SIZE-1:0] yt,
  input  logic [V_SIZE-1:0] yb,
  output logic [AW-1:0]     address,
  output logic              last
);
  logic [H_SIZE-1:0] x_q, x_d, xl_q, xl_d, xr_q, xr_d;
  logic [V_SIZE-1:0] y_q, y_d, yb_q, yb_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic row_end;
  always_comb begin
    row_end = x_q == xr_q;
    last = row_end && y_q == yb_q;
    address = row_base_q + AW'(x_q);
    xl_d = load ? xl : xl_q;
    xr_d = load ? xr : xr_q;
    yb_d = load ? yb : yb_q;
    x_d = load ? xl : advance ? (row_end ? xl_q : x_q + H_SIZE'(1)) : x_q;
    y_d = load ? yt : (advance && row_end) ? y_q + V_SIZE'(1) : y_q;
    // the only multiply is by a constant, once per command
    row_base_d = load ? AW'(yt) * AW'(H_DISPLAY)
               : (advance && row_end) ? row_base_q + AW'(H_DISPLAY) : row_base_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      xl_q <= '0;
      xr_q <= '0;
      yb_q <= '0;
      row_base_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      xl_q <= xl_d;
      xr_q <= xr_d;
      yb_q <= yb_d;
      row_base_q <= row_base_d;
    end
  end
endmodule

// File: rtl/vga_fb_rect_fill.sv
// vga_fb_rect_fill: clips rectangle-fill commands to the display and writes them pixel by pixel over Avalon-MM.
module vga_fb_rect_fill import vga_fb_pkg::*; #(
  parameter int AVN_AW = 19,
  parameter int AVN_DW = 16,
  parameter int RGB_SIZE = 12
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [H_SIZE-1:0]   cmd_x0,
  input  logic [H_SIZE-1:0]   cmd_x1,
  input  logic [V_SIZE-1:0]   cmd_y0,
  input  logic [V_SIZE-1:0]   cmd_y1,
  input  logic [RGB_SIZE-1:0] cmd_rgb,
  output logic                busy,
  output logic                done,
  output logic                framebuffer_avn_write,
  output logic                framebuffer_avn_read,
  output logic [AVN_AW-1:0]   framebuffer_avn_address,
  output logic [AVN_DW-1:0]   framebuffer_avn_writedata,
  output logic [AVN_DW/8-1:0] framebuffer_avn_byteenable,
  input  logic                framebuffer_avn_waitrequest
);
  localparam logic [H_SIZE-1:0] H_LAST = H_SIZE'(H_DISPLAY - 1);
  localparam logic [V_SIZE-1:0] V_LAST = V_SIZE'(V_DISPLAY - 1);
  if (H_DISPLAY * V_DISPLAY > (1 << AVN_AW)) begin : g_aw_chk
    $error("AVN_AW cannot address the whole frame");
  end
  if (AVN_DW < RGB_SIZE || AVN_DW % 8 != 0 || RGB_SIZE > CMD_RGB_W) begin : g_dw_chk
    $error("bad AVN_DW / RGB_SIZE combination");
  end
  fill_state_t state_q, state_d;
  fill_cmd_t cmd_q, cmd_d;
  logic [H_SIZE-1:0] xl, xr;
  logic [V_SIZE-1:0] yt, yb;
  logic off_screen, load, fire, last;
  logic [AVN_AW-1:0] gen_addr;
  always_comb begin
    cmd_d = (state_q == IDLE && cmd_valid)
          ? '{x0: cmd_x0, x1: cmd_x1, y0: cmd_y0, y1: cmd_y1, rgb: CMD_RGB_W'(cmd_rgb)} : cmd_q;
    xl = cmd_q.x0 < cmd_q.x1 ? cmd_q.x0 : cmd_q.x1;
    xr = cmd_q.x0 < cmd_q.x1 ? cmd_q.x1 : cmd_q.x0;
    yt = cmd_q.y0 < cmd_q.y1 ? cmd_q.y0 : cmd_q.y1;
    yb = cmd_q.y0 < cmd_q.y1 ? cmd_q.y1 : cmd_q.y0;
    off_screen = xl > H_LAST || yt > V_LAST;
    load = state_q == CLIP && !off_screen;
    fire = state_q == WRITE && !framebuffer_avn_waitrequest;
  end
  vga_fb_addr_gen #(.AW(AVN_AW)) u_addr_gen (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .load    (load),
    .advance (fire),
    .xl      (xl),
    .xr      (xr > H_LAST ? H_LAST : xr),
    .yt      (yt),
    .yb      (yb > V_LAST ? V_LAST : yb),
    .address (gen_addr),
    .last    (last)
  );
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = cmd_valid ? CLIP : IDLE;
      CLIP:    state_d = off_screen ? DONE : WRITE;
      WRITE:   state_d = (fire && last) ? DONE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  // write-side outputs are zeroed outside WRITE so the bus idles clean
  always_comb begin
    cmd_ready = state_q == IDLE;
    busy = state_q == CLIP || state_q == WRITE;
    done = state_q == DONE;
    framebuffer_avn_write = state_q == WRITE;
    framebuffer_avn_read = 1'b0;
    framebuffer_avn_address = framebuffer_avn_write ? gen_addr : '0;
    framebuffer_avn_writedata = framebuffer_avn_write ? AVN_DW'(cmd_q.rgb) : '0;
    framebuffer_avn_byteenable = framebuffer_avn_write ? '1 : '0;
  end
endmodule

// File: tb/tb_vga_fb_rect_fill.sv
// tb_vga_fb_rect_fill: scoreboarded Avalon slave model with directed rectangle-fill commands.
module tb_vga_fb_rect_fill;
  import vga_fb_pkg::*;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic cmd_valid, cmd_ready, busy, done;
  logic [H_SIZE-1:0] cmd_x0, cmd_x1;
  logic [V_SIZE-1:0] cmd_y0, cmd_y1;
  logic [11:0] cmd_rgb;
  logic wr, rd, waitreq;
  logic [18:0] addr;
  logic [15:0] wdata;
  logic [1:0] be;
  typedef struct { int a; int d; } exp_t;
  exp_t exp_q[$];
  logic [15:0] mem [int];
  int checks = 0, failures = 0, fires = 0, cyc = 0, last_addr = -1;
  int stall_left = 0;
  bit rnd = 0;
  int t1_addr [6] = '{642, 643, 644, 1282, 1283, 1284};
  int t3_addr [8] = '{306556, 306557, 306558, 306559, 307196, 307197, 307198, 307199};
  int t6_addr [6] = '{10, 11, 12, 650, 651, 652};

  vga_fb_rect_fill dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_rgb(cmd_rgb),
    .busy(busy), .done(done), .framebuffer_avn_write(wr), .framebuffer_avn_read(rd),
    .framebuffer_avn_address(addr), .framebuffer_avn_writedata(wdata),
    .framebuffer_avn_byteenable(be), .framebuffer_avn_waitrequest(waitreq)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int a, input int d);
    exp_q.push_back('{a, d});
  endtask

  // slave: scripted stall bursts, otherwise random or zero waitrequest
  initial begin
    waitreq = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (stall_left > 0) begin
        waitreq = 1'b1;
        if (wr) stall_left--;
      end else waitreq = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // monitor: every cycle with a write request is checked against the queue head
  always @(negedge sys_clk) begin
    if (wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got=addr %0d expected=no write", addr);
      end else begin
        chk("wr_addr", longint'(addr), longint'(exp_q[0].a));
        chk("wr_data", longint'(wdata), longint'(exp_q[0].d));
        chk("wr_be", longint'(be), 3);
        if (!waitreq) begin
          mem[int'(addr)] = wdata;
          last_addr = int'(addr);
          fires++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_cmd(input int x0, input int x1, input int y0, input int y1, input int rgb,
                         input int exp_lat, input int exp_wr_cycles);
    int acc, wr_cyc;
    bit got;
    @(negedge sys_clk);
    cmd_x0 = H_SIZE'(x0);
    cmd_x1 = H_SIZE'(x1);
    cmd_y0 = V_SIZE'(y0);
    cmd_y1 = V_SIZE'(y1);
    cmd_rgb = 12'(rgb);
    cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmd_ready) got = 1;
      else @(negedge sys_clk);
    end
    chk("cmd_accepted", longint'(got), 1);
    acc = cyc;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    wr_cyc = 0;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) got = 1;
      else begin
        chk("ready_low_while_busy", longint'(cmd_ready), 0);
        chk("busy_high", longint'(busy), 1);
        if (wr) wr_cyc++;
        @(negedge sys_clk);
      end
    end
    chk("done_seen", longint'(got), 1);
    if (exp_lat >= 0) chk("done_latency", longint'(cyc - acc), longint'(exp_lat));
    if (exp_wr_cycles >= 0) chk("write_cycles", longint'(wr_cyc), longint'(exp_wr_cycles));
    chk("busy_low_at_done", longint'(busy), 0);
    chk("write_low_at_done", longint'(wr), 0);
    @(negedge sys_clk);
    chk("ready_after_done", longint'(cmd_ready), 1);
    chk("done_one_cycle", longint'(done), 0);
  endtask

  initial begin
    int f0;
    bit hit;
    cmd_valid = 1'b0;
    cmd_x0 = '0;
    cmd_x1 = '0;
    cmd_y0 = '0;
    cmd_y1 = '0;
    cmd_rgb = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_write", longint'(wr), 0);
    chk("rst_read", longint'(rd), 0);
    chk("rst_address", longint'(addr), 0);
    chk("rst_writedata", longint'(wdata), 0);
    chk("rst_byteenable", longint'(be), 0);
    sys_rst = 1'b0;

    // 1: 3x2 block, no stalls, N=6 -> done at accept+8
    rnd = 0;
    foreach (t1_addr[i]) push_exp(t1_addr[i], 'h0F0A);
    run_cmd(2, 4, 1, 2, 'hF0A, 8, 6);
    chk("t1_queue_empty", longint'(exp_q.size()), 0);

    // 2: swapped corners under random stalls
    mem.delete();
    rnd = 1;
    foreach (t1_addr[i]) push_exp(t1_addr[i], 'h0F0A);
    run_cmd(4, 2, 2, 1, 'hF0A, -1, -1);
    chk("t2_queue_empty", longint'(exp_q.size()), 0);
    chk("t2_mem_count", longint'(mem.num()), 6);
    foreach (t1_addr[i]) chk("t2_mem_data", longint'(mem.exists(t1_addr[i]) ? mem[t1_addr[i]] : 16'hDEAD), 'h0F0A);

    // 3: bottom-right partial clip
    foreach (t3_addr[i]) push_exp(t3_addr[i], 'h0ABC);
    run_cmd(636, 700, 478, 600, 'hABC, -1, -1);
    chk("t3_queue_empty", longint'(exp_q.size()), 0);
    chk("t3_last_addr", longint'(last_addr), 307199);

    // 4: fully off-screen column
    rnd = 0;
    f0 = fires;
    run_cmd(700, 700, 10, 20, 'h123, 2, 0);
    chk("t4_no_writes", longint'(fires - f0), 0);

    // 5: single pixel behind five stalled cycles
    f0 = fires;
    stall_left = 5;
    push_exp(5 * 640 + 7, 'h0555);
    run_cmd(7, 7, 5, 5, 'h555, 8, 6);
    chk("t5_one_write", longint'(fires - f0), 1);

    // 6: reset in the third row of a 10x10 fill, then a fresh command
    for (int y = 200; y < 210; y++)
      for (int x = 100; x < 110; x++) push_exp(y * 640 + x, 'h0321);
    f0 = fires;
    @(negedge sys_clk);
    cmd_x0 = 10'd100;
    cmd_x1 = 10'd109;
    cmd_y0 = 10'd200;
    cmd_y1 = 10'd209;
    cmd_rgb = 12'h321;
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge sys_clk);
      #1;
      if (fires - f0 >= 25) hit = 1;
    end
    chk("t6_reached_row2", longint'(hit), 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t6_write_after_rst", longint'(wr), 0);
    chk("t6_busy_after_rst", longint'(busy), 0);
    chk("t6_fires_before_rst", longint'(fires - f0), 25);
    exp_q.delete();
    sys_rst = 1'b0;
    foreach (t6_addr[i]) push_exp(t6_addr[i], 'h0777);
    run_cmd(12, 10, 1, 0, 'h777, 8, 6);

    chk("final_queue_empty", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
